ysyx_23060136_ifu_fetch_ctrl: RTL and testbench

Fetch sequencer for the IFU front end. It owns the fetch PC and issues one instruction request at a time to the I-cache. It applies branch and BHT redirects, and discards any response already in flight when a redirect arrives. It presents a registered {pc, inst, valid} to the IFU2 pipeline register under decode back-pressure (`FORWARD_stallIF`).

---
 rtl/ysyx_23060136_ifu_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_ysyx_23060136_ifu_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_ifu_fetch_ctrl.sv
// IFU fetch sequencer: owns the fetch PC, issues one I-cache request at a time,
// applies branch/BHT redirects and presents {pc, inst, valid} to the IFU2 register.
//
// state | meaning
// IDLE  | first cycle after reset, loads req_addr from fetch_pc
// REQ   | request to I-cache pending or about to be raised
// WAIT  | request accepted, waiting for the response pulse
module ysyx_23060136_ifu_fetch_ctrl #(
    parameter int                BITS_W = 32,
    parameter logic [BITS_W-1:0] PC_RST = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BRANCH_flushIF,
    input  logic [BITS_W-1:0] BRANCH_target,
    input  logic              BHT_flushIF,
    input  logic [BITS_W-1:0] BHT_target,
    input  logic              FORWARD_stallIF,
    output logic              ifu_req_valid,
    output logic [BITS_W-1:0] ifu_req_addr,
    input  logic              icache_req_ready,
    input  logic              icache_resp_valid,
    input  logic [BITS_W-1:0] icache_resp_inst,
    output logic [BITS_W-1:0] IFU1_pc,
    output logic [BITS_W-1:0] IFU1_inst,
    output logic              IFU1_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic [BITS_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [BITS_W-1:0] req_addr, req_addr_nxt;
    logic [BITS_W-1:0] out_pc, out_pc_nxt;
    logic [BITS_W-1:0] out_inst, out_inst_nxt;
    logic              drop, drop_nxt;
    logic              req_held, req_held_nxt;
    logic              out_valid, out_valid_nxt;
    logic              redir;
    logic              req_valid;
    logic              hs;
    logic [BITS_W-1:0] target;

    assign redir  = (BRANCH_flushIF | BHT_flushIF) & ~FORWARD_stallIF;
    assign target = (BRANCH_flushIF ? BRANCH_target : BHT_target) & ~BITS_W'(3);

    // Once raised, the request stays up until accepted: the output slot was
    // already freed in the cycle it was first asserted.
    assign req_valid = (state == REQ) & (req_held | ~out_valid | ~FORWARD_stallIF);
    assign hs        = req_valid & icache_req_ready;

    assign ifu_req_valid = req_valid;
    assign ifu_req_addr  = req_addr;
    assign IFU1_pc       = out_pc;
    assign IFU1_inst     = out_inst;
    assign IFU1_valid    = out_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= PC_RST;
            req_addr  <= PC_RST;
            drop      <= 1'b0;
            req_held  <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            req_addr  <= req_addr_nxt;
            drop      <= drop_nxt;
            req_held  <= req_held_nxt;
            out_valid <= out_valid_nxt;
            out_pc    <= out_pc_nxt;
            out_inst  <= out_inst_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        req_addr_nxt  = req_addr;
        drop_nxt      = drop;
        req_held_nxt  = req_held;
        out_valid_nxt = out_valid;
        out_pc_nxt    = out_pc;
        out_inst_nxt  = out_inst;

        if (out_valid && !FORWARD_stallIF)
            out_valid_nxt = 1'b0;
        if (redir) begin
            out_valid_nxt = 1'b0;
            fetch_pc_nxt  = target;
        end

        case (state)
            IDLE: begin
                state_nxt    = REQ;
                req_addr_nxt = redir ? target : fetch_pc;
            end
            REQ: begin
                req_held_nxt = req_valid & ~hs;
                if (hs) begin
                    state_nxt = WAIT;
                    if (redir)
                        drop_nxt = 1'b1;
                end else if (redir) begin
                    if (req_held) begin
                        drop_nxt = 1'b1;
                    end else begin
                        // Nothing committed to the cache yet, so retarget in place.
                        req_addr_nxt = target;
                        req_held_nxt = 1'b0;
                    end
                end
            end
            WAIT: begin
                req_held_nxt = 1'b0;
                if (icache_resp_valid) begin
                    state_nxt = REQ;
                    if (drop) begin
                        drop_nxt     = 1'b0;
                        req_addr_nxt = redir ? target : fetch_pc;
                    end else if (redir) begin
                        req_addr_nxt = target;
                    end else begin
                        out_valid_nxt = 1'b1;
                        out_pc_nxt    = req_addr;
                        out_inst_nxt  = icache_resp_inst;
                        fetch_pc_nxt  = req_addr + BITS_W'(4);
                        req_addr_nxt  = req_addr + BITS_W'(4);
                    end
                end else if (redir) begin
                    drop_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch_ctrl.sv
// Randomized bench for the IFU fetch sequencer: behavioural I-cache plus a
// program-order scoreboard of expected presented PCs.
module tb_ysyx_23060136_ifu_fetch_ctrl;

    localparam logic [31:0] PC0 = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        BRANCH_flushIF = 1'b0;
    logic [31:0] BRANCH_target = '0;
    logic        BHT_flushIF = 1'b0;
    logic [31:0] BHT_target = '0;
    logic        FORWARD_stallIF = 1'b0;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        icache_req_ready = 1'b0;
    logic        icache_resp_valid = 1'b0;
    logic [31:0] icache_resp_inst = '0;
    logic [31:0] IFU1_pc;
    logic [31:0] IFU1_inst;
    logic        IFU1_valid;

    always #5 clk = ~clk;

    ysyx_23060136_ifu_fetch_ctrl #(.BITS_W(32), .PC_RST(PC0)) dut (
        .clk(clk), .rst(rst),
        .BRANCH_flushIF(BRANCH_flushIF), .BRANCH_target(BRANCH_target),
        .BHT_flushIF(BHT_flushIF), .BHT_target(BHT_target),
        .FORWARD_stallIF(FORWARD_stallIF),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .icache_req_ready(icache_req_ready),
        .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
        .IFU1_pc(IFU1_pc), .IFU1_inst(IFU1_inst), .IFU1_valid(IFU1_valid)
    );

    int total = 0;
    int bad = 0;
    int cyc = -1;
    int consumed = 0;
    bit started = 0;
    bit directed = 1;
    logic [31:0] exp_q[$];

    // behavioural I-cache: one outstanding request, response after cnt cycles
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    // previous-cycle samples
    bit          p_ok = 0;
    bit          p_wait = 0;
    bit          p_redir = 0;
    bit          p_out_stall = 0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_pc = '0;
    logic [31:0] p_inst = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(4))
            0: return 32'h3000_0100;
            1: return 32'h3000_0106;
            2: return 32'hFFFF_FFFC;
            3: return 32'h3000_0200;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic redir;
        logic [31:0] e;
        if (rst && started) begin
            redir = (BRANCH_flushIF | BHT_flushIF) & ~FORWARD_stallIF;
            if (cyc == 0) chk("idle_no_req", ifu_req_valid, 0);
            if (cyc == 1) begin
                chk("first_req_valid", ifu_req_valid, 1);
                chk("first_req_addr", ifu_req_addr, PC0);
            end
            if (cyc == 2) chk("out_empty_c2", IFU1_valid, 0);
            if (cyc == 3) begin
                chk("second_req_valid", ifu_req_valid, 1);
                chk("second_req_addr", ifu_req_addr, PC0 + 4);
                chk("first_out_valid", IFU1_valid, 1);
                chk("first_out_pc", IFU1_pc, PC0);
            end
            if (p_ok && p_wait && !p_redir) begin
                chk("req_held_valid", ifu_req_valid, 1);
                chk("req_held_addr", ifu_req_addr, p_addr);
            end
            if (p_ok && p_out_stall) begin
                chk("stall_hold_valid", IFU1_valid, 1);
                chk("stall_hold_pc", IFU1_pc, p_pc);
                chk("stall_hold_inst", IFU1_inst, p_inst);
            end
            if (p_ok && IFU1_valid && FORWARD_stallIF && ifu_req_valid)
                chk("no_new_req_under_stall", p_wait, 1);
            if (ifu_req_valid && icache_req_ready) begin
                chk("one_outstanding", pend, 0);
                chk("req_addr_aligned", ifu_req_addr & 32'h3, 0);
                pend = 1;
                cnt = directed ? 1 : $urandom_range(1, 4);
                pend_addr = ifu_req_addr;
            end
            if (IFU1_valid && !FORWARD_stallIF && !redir) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got pc %h want none", IFU1_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", IFU1_pc, e);
                    chk("out_inst", IFU1_inst, mem(e));
                    exp_q.push_back(e + 4);
                    consumed++;
                end
            end
            p_ok        = 1;
            p_wait      = ifu_req_valid & ~icache_req_ready;
            p_redir     = redir;
            p_out_stall = IFU1_valid & FORWARD_stallIF;
            p_addr      = ifu_req_addr;
            p_pc        = IFU1_pc;
            p_inst      = IFU1_inst;
        end else begin
            p_ok = 0;
        end
    end

    // stimulus
    initial begin
        int low_cnt;
        int r;
        low_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", ifu_req_valid, 0);
        chk("rst_out_valid", IFU1_valid, 0);
        chk("rst_out_pc", IFU1_pc, 0);
        chk("rst_out_inst", IFU1_inst, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        started = 1;
        exp_q.push_back(PC0);
        for (int c = 0; c < 4000; c++) begin
            directed = (c < 6);
            icache_resp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    icache_resp_valid = 1'b1;
                    icache_resp_inst = mem(pend_addr);
                    pend = 0;
                end
            end
            BRANCH_flushIF = 1'b0;
            BHT_flushIF = 1'b0;
            if (directed) begin
                FORWARD_stallIF = 1'b0;
                icache_req_ready = 1'b1;
            end else begin
                FORWARD_stallIF = ($urandom_range(3) == 0);
                if (low_cnt > 0) begin
                    icache_req_ready = 1'b0;
                    low_cnt--;
                end else if ($urandom_range(15) == 0) begin
                    icache_req_ready = 1'b0;
                    low_cnt = 3;
                end else begin
                    icache_req_ready = 1'b1;
                end
                r = $urandom_range(11);
                BRANCH_target = pick_tgt();
                BHT_target = pick_tgt();
                if (r == 0) BRANCH_flushIF = 1'b1;
                if (r == 1) BHT_flushIF = 1'b1;
                if (r == 2) begin
                    BRANCH_flushIF = 1'b1;
                    BHT_flushIF = 1'b1;
                end
                if ((BRANCH_flushIF || BHT_flushIF) && !FORWARD_stallIF) begin
                    exp_q.delete();
                    exp_q.push_back((BRANCH_flushIF ? BRANCH_target : BHT_target) & ~32'h3);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        BRANCH_flushIF = 1'b0;
        BHT_flushIF = 1'b0;
        icache_resp_valid = 1'b0;
        pend = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req_valid", ifu_req_valid, 0);
        chk("mid_rst_out_valid", IFU1_valid, 0);
        chk("mid_rst_out_pc", IFU1_pc, 0);
        chk("mid_rst_out_inst", IFU1_inst, 0);
        total++;
        if (consumed < 200) begin
            bad++;
            $display("FAIL progress: got %0d consumed want at least 200", consumed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
